truth_table_sweeper: RTL and testbench



---
 rtl/sweep_pkg.sv | 21 ++
 rtl/sweep_settle_cnt.sv | 37 +++
 rtl/truth_table_sweeper.sv | 168 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding, vector-count helper and golden truth tables for the sweeper
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FIN
    } sweep_state_t;

    function automatic int n_vec(input int n);
        return 1 << n;
    endfunction

    // Golden minterm vectors for the 3-input guide functions, bit i = f(i)
    localparam logic [7:0] SOP_2357 = 8'hAC;
    localparam logic [7:0] SOP_XOR3 = 8'h96;
    localparam logic [7:0] SOP_MAJ3 = 8'hE8;

endpackage

// File: rtl/sweep_settle_cnt.sv
// rtl/sweep_settle_cnt.sv - loadable down-counter with zero flag, paces the per-vector settle wait
module sweep_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks a combinational function through all inputs and captures its truth table
// Define SWEEP_EXPECT_CHECK_EN to build the EXPECTED compare (match/first_miss); otherwise both read 0.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                          N_INPUTS      = 3,
    parameter int                          SETTLE_CYCLES = 1,
    parameter logic [n_vec(N_INPUTS)-1:0]  EXPECTED      = SOP_2357
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [N_INPUTS-1:0]         dut_in,
    input  logic                        dut_out,
    output logic                        busy,
    output logic                        done,
    output logic [n_vec(N_INPUTS)-1:0]  minterms,
    output logic                        match,
    output logic [N_INPUTS-1:0]         first_miss
);

    localparam int N_VEC = n_vec(N_INPUTS);
    localparam int IW    = N_INPUTS + 1;
    localparam int CW    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    sweep_state_t         state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N_INPUTS-1:0]  dut_in_q, dut_in_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [N_VEC-1:0]     minterms_q, minterms_d;
    logic                 match_q, match_d;
    logic [N_INPUTS-1:0]  first_miss_q, first_miss_d;

    logic                 cnt_load;
    logic                 cnt_dec;
    logic [CW-1:0]        cnt_count;
    logic                 cnt_zero;

    logic [N_VEC-1:0]     final_vec;
    logic                 cmp_match;
    logic [N_INPUTS-1:0]  cmp_first_miss;

    sweep_settle_cnt #(
        .W (CW)
    ) u_settle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .value (CW'(SETTLE_CYCLES)),
        .count (cnt_count),
        .zero  (cnt_zero)
    );

    // Truth table as it will look once the current sample lands; the compare looks at this
    always_comb begin
        final_vec = minterms_q;
        final_vec[idx_q[N_INPUTS-1:0]] = dut_out;
    end

`ifdef SWEEP_EXPECT_CHECK_EN
    logic [N_VEC-1:0] diff;

    always_comb begin
        diff           = final_vec ^ EXPECTED;
        cmp_match      = (diff == '0);
        cmp_first_miss = '0;
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (diff[i]) begin
                cmp_first_miss = i[N_INPUTS-1:0];
            end
        end
    end
`else
    logic unused_expected;

    assign unused_expected = ^EXPECTED;
    assign cmp_match       = 1'b0;
    assign cmp_first_miss  = '0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dut_in_d     = dut_in_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        minterms_d   = minterms_q;
        match_d      = match_q;
        first_miss_d = first_miss_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = APPLY;
                    idx_d        = '0;
                    minterms_d   = '0;
                    match_d      = 1'b0;
                    first_miss_d = '0;
                    busy_d       = 1'b1;
                end
            end
            APPLY: begin
                dut_in_d = idx_q[N_INPUTS-1:0];
                cnt_load = 1'b1;
                state_d  = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
            end
            SETTLE: begin
                cnt_dec = 1'b1;
                if ((cnt_count == CW'(1)) || cnt_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                minterms_d = final_vec;
                if (idx_q == IW'(N_VEC - 1)) begin
                    state_d      = FIN;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    match_d      = cmp_match;
                    first_miss_d = cmp_first_miss;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = APPLY;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            minterms_q   <= '0;
            match_q      <= 1'b0;
            first_miss_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dut_in_q     <= dut_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            minterms_q   <= minterms_d;
            match_q      <= match_d;
            first_miss_q <= first_miss_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign minterms   = minterms_q;
    assign match      = match_q;
    assign first_miss = first_miss_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper at settle 1, 0 and 3
module tb_truth_table_sweeper;

    localparam int         NV   = 8;
    localparam logic [7:0] GOLD = 8'hAC;

    typedef struct {
        int         d;
        int         acc;
        int         per;
        logic [7:0] mt;
        logic       m;
        logic [2:0] fm;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       fault = 1'b0;
    logic [2:0] start_r = '0;

    logic [2:0] dut_in_w [3];
    logic       f_w      [3];
    logic       busy_w   [3];
    logic       done_w   [3];
    logic       match_w  [3];
    logic [7:0] mt_w     [3];
    logic [2:0] fm_w     [3];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt [3] = '{0, 0, 0};
    exp_t sb_q [$];
    logic [2:0] tr_in   [64];
    logic       tr_busy [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic fmodel(input logic [2:0] v, input logic flt);
        logic [7:0] g;
        g = GOLD;
        return g[v] & ~(flt && (v == 3'd5));
    endfunction

    function automatic int per_of(input int d);
        return (d == 0) ? 3 : (d == 1) ? 2 : 5;
    endfunction

    function automatic exp_t build_exp(input int d, input int acc, input logic flt);
        exp_t e;
        e.d   = d;
        e.acc = acc;
        e.per = per_of(d);
        e.mt  = '0;
        for (int v = 0; v < NV; v++) e.mt[v] = fmodel(3'(v), flt);
        e.m  = 1'b0;
        e.fm = '0;
`ifdef SWEEP_EXPECT_CHECK_EN
        begin
            logic [7:0] diff;
            diff = e.mt ^ GOLD;
            e.m  = (diff == 8'h00);
            for (int v = NV - 1; v >= 0; v--) if (diff[v]) e.fm = 3'(v);
        end
`endif
        return e;
    endfunction

    assign f_w[0] = fmodel(dut_in_w[0], fault);
    assign f_w[1] = fmodel(dut_in_w[1], fault);
    assign f_w[2] = fmodel(dut_in_w[2], fault);

    truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(1), .EXPECTED(GOLD)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .dut_in(dut_in_w[0]), .dut_out(f_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .minterms(mt_w[0]), .match(match_w[0]), .first_miss(fm_w[0]));
    truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(0), .EXPECTED(GOLD)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .dut_in(dut_in_w[1]), .dut_out(f_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .minterms(mt_w[1]), .match(match_w[1]), .first_miss(fm_w[1]));
    truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(3), .EXPECTED(GOLD)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .dut_in(dut_in_w[2]), .dut_out(f_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .minterms(mt_w[2]), .match(match_w[2]), .first_miss(fm_w[2]));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic start_sweep(input int d, input int hold);
        @(negedge clk);
        start_r[d] = 1'b1;
        sb_q.push_back(build_exp(d, cyc + 1, fault));
        repeat (hold) @(negedge clk);
        start_r[d] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq("sweep_timeout", 32'(sb_q.size() == 0), 32'd1);
        sb_q.delete();
    endtask

    task automatic chk_zero_outputs(input int d);
        chk_eq("rst_dut_in", 32'(dut_in_w[d]), 32'd0);
        chk_eq("rst_busy", 32'(busy_w[d]), 32'd0);
        chk_eq("rst_done", 32'(done_w[d]), 32'd0);
        chk_eq("rst_minterms", 32'(mt_w[d]), 32'd0);
        chk_eq("rst_match", 32'(match_w[d]), 32'd0);
        chk_eq("rst_first_miss", 32'(fm_w[d]), 32'd0);
    endtask

    // Trace dut_in/busy of the active sweep and score it when done fires
    always @(negedge clk) begin : monitor
        int   k;
        int   errs;
        exp_t e;
        if (sb_q.size() != 0) begin
            k = cyc - sb_q[0].acc + 1;
            if (k >= 1 && k < 64) begin
                tr_in[k]   <= dut_in_w[sb_q[0].d];
                tr_busy[k] <= busy_w[sb_q[0].d];
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (done_w[d] === 1'b1) begin
                done_cnt[d] <= done_cnt[d] + 1;
                chk_eq("done_expected", 32'(sb_q.size() != 0 && sb_q[0].d == d), 32'd1);
                if (sb_q.size() != 0 && sb_q[0].d == d) begin
                    e = sb_q.pop_front();
                    k = cyc - e.acc + 1;
                    chk_eq("done_cycle", 32'(k), 32'(NV * e.per + 1));
                    chk_eq("minterms", 32'(mt_w[d]), 32'(e.mt));
                    chk_eq("match", 32'(match_w[d]), 32'(e.m));
                    chk_eq("first_miss", 32'(fm_w[d]), 32'(e.fm));
                    errs = 0;
                    for (int c = 1; c <= NV * e.per && c < 64; c++) begin
                        if (tr_busy[c] !== 1'b1) errs++;
                        if (c >= 2 && tr_in[c] !== 3'((c - 2) / e.per)) errs++;
                    end
                    if (dut_in_w[d] !== 3'(NV - 1)) errs++;
                    if (busy_w[d] !== 1'b0) errs++;
                    chk_eq("hold_busy_errs", 32'(errs), 32'd0);
                end
            end
        end
    end

    initial begin
        int n0;
        #1;
        for (int d = 0; d < 3; d++) chk_zero_outputs(d);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        start_sweep(0, 1);
        wait_idle(60);

        fault = 1'b1;
        start_sweep(0, 1);
        wait_idle(60);
        repeat (3) @(negedge clk);
        chk_eq("dut_in_hold_after", 32'(dut_in_w[0]), 32'd7);
        chk_eq("minterms_readable", 32'(mt_w[0]), 32'h8C);

        fault = 1'b0;
        start_sweep(1, 1);
        wait_idle(60);
        start_sweep(2, 1);
        wait_idle(80);

        n0 = done_cnt[0];
        start_sweep(0, 25);
        wait_idle(10);
        repeat (6) @(negedge clk);
        chk_eq("held_one_sweep", 32'(done_cnt[0] - n0), 32'd1);
        chk_eq("held_no_restart", 32'(busy_w[0]), 32'd0);

        start_sweep(0, 1);
        repeat (24) @(negedge clk);
        start_sweep(0, 1);
        chk_eq("minterms_cleared", 32'(mt_w[0]), 32'd0);
        chk_eq("b2b_busy", 32'(busy_w[0]), 32'd1);
        wait_idle(60);

        fault = 1'b1;
        start_sweep(0, 1);
        repeat (13) @(negedge clk);
        chk_eq("dut_in_vec4", 32'(dut_in_w[0]), 32'd4);
        n0 = done_cnt[0];
        rst_n = 1'b0;
        #1;
        chk_zero_outputs(0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        chk_eq("no_done_in_reset", 32'(done_cnt[0] - n0), 32'd0);
        rst_n = 1'b1;
        start_sweep(0, 1);
        wait_idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
